// File: rtl/jk_register_bank_pkg.sv
// Shared definitions for the JK register bank: mode encodings and the JK
// next-state rule used by every cell.
package jk_register_bank_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_JK    = 2'b00;
    localparam logic [MODE_W-1:0] MODE_UP    = 2'b01;
    localparam logic [MODE_W-1:0] MODE_DOWN  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_SHIFT = 2'b11;

    // Classic JK truth table: 00 hold, 01 clear, 10 set, 11 toggle.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic n;
        case ({j, k})
            2'b00:   n = q;
            2'b01:   n = 1'b0;
            2'b10:   n = 1'b1;
            default: n = ~q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jk_register_bank_if.sv
// Control/status bundle of the JK register bank. The master drives the
// controls; the slave (the bank) returns state and status.
interface jk_register_bank_if
    import jk_register_bank_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic              en;
    logic [MODE_W-1:0] mode;
    logic [WIDTH-1:0]  j;
    logic [WIDTH-1:0]  k;
    logic              sin;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  qb;
    logic              tc;
    logic              wrap;

    modport master (
        output en, mode, j, k, sin,
        input  q, qb, tc, wrap
    );

    modport slave (
        input  en, mode, j, k, sin,
        output q, qb, tc, wrap
    );
endinterface

// File: rtl/jk_register_bank_jk_cell.sv
// Single JK flip-flop with synchronous active-high reset, per-cell reset
// value and update enable. qb is derived from the flop so it never skews.
module jk_cell
    import jk_register_bank_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic q_q;
    logic q_d;

    // Next state: apply the JK rule only when enabled, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = jk_next(q_q, j, k);
        end
    end

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: rtl/jk_register_bank.sv
// Multi-mode JK register bank: WIDTH JK cells whose J/K pairs are steered
// by mode to act as an independent register, up counter, down counter or
// serial-in shift register. Also provides terminal count and wrap pulse.
module jk_register_bank
    import jk_register_bank_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst,
    jk_register_bank_if.slave   bus
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] j_in;
    logic [WIDTH-1:0] k_in;
    logic             tc;
    logic             wrap_q;
    logic             wrap_d;

    // Ripple toggle terms: a bit toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & q[i-1];
            t_dn[i] = t_dn[i-1] & ~q[i-1];
        end
    end

    assign shift_val = {q[WIDTH-2:0], bus.sin};

    // Mode mux: choose what drives each cell's J/K pair.
    always_comb begin
        j_in = '0;
        k_in = '0;
        case (bus.mode)
            MODE_JK: begin
                j_in = bus.j;
                k_in = bus.k;
            end
            MODE_UP: begin
                j_in = t_up;
                k_in = t_up;
            end
            MODE_DOWN: begin
                j_in = t_dn;
                k_in = t_dn;
            end
            default: begin
                // Set/clear each cell from its lower neighbour (or sin for cell 0).
                j_in = shift_val;
                k_in = ~shift_val;
            end
        endcase
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell #(
            .RST_VAL (RESET_VALUE[gi])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .en  (bus.en),
            .j   (j_in[gi]),
            .k   (k_in[gi]),
            .q   (q[gi]),
            .qb  (qb[gi])
        );
    end

    // Terminal count follows q and mode directly, only meaningful for counting modes.
    always_comb begin
        tc = 1'b0;
        if (bus.mode == MODE_UP) begin
            tc = &q;
        end else if (bus.mode == MODE_DOWN) begin
            tc = ~|q;
        end
    end

    // A wrap occurs on an enabled edge taken while sitting at terminal count.
    always_comb begin
        wrap_d = bus.en & tc;
    end

    // Wrap pulse register, aligned with the first cycle showing the wrapped value.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bus.q    = q;
    assign bus.qb   = qb;
    assign bus.tc   = tc;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed testbench for jk_register_bank (WIDTH=4, RESET_VALUE=4'b1010).
module tb_jk_register_bank;

    localparam int         WIDTH = 4;
    localparam logic [3:0] RV    = 4'b1010;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    jk_register_bank_if #(.WIDTH(WIDTH)) bus ();

    jk_register_bank #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load an arbitrary value using JK mode (set where 1, clear where 0).
    task automatic load(input logic [3:0] v);
        bus.en   = 1'b1;
        bus.mode = 2'b00;
        bus.j    = v;
        bus.k    = ~v;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b0; bus.mode = 2'b00;
        bus.j = '0; bus.k = '0; bus.sin = 1'b0;
        step();
        step();
        total_cnt++; if (bus.q !== 4'b1010) $display("FAIL reset_q: got %b want %b", bus.q, 4'b1010); else pass_cnt++;
        total_cnt++; if (bus.qb !== 4'b0101) $display("FAIL reset_qb: got %b want %b", bus.qb, 4'b0101); else pass_cnt++;
        total_cnt++; if (bus.wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", bus.wrap); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_jk();
        bus.en = 1'b1; bus.mode = 2'b00;
        bus.j = 4'b0011; bus.k = 4'b0101;
        step();
        total_cnt++; if (bus.q !== 4'b1011) $display("FAIL jk_q: got %b want %b", bus.q, 4'b1011); else pass_cnt++;
        total_cnt++; if (bus.qb !== 4'b0100) $display("FAIL jk_qb: got %b want %b", bus.qb, 4'b0100); else pass_cnt++;
        total_cnt++; if (bus.tc !== 1'b0) $display("FAIL jk_tc: got %b want 0", bus.tc); else pass_cnt++;
        // en=0 holds state even with active J/K
        bus.en = 1'b0; bus.j = 4'b1111; bus.k = 4'b1111;
        step();
        total_cnt++; if (bus.q !== 4'b1011) $display("FAIL jk_hold: got %b want %b", bus.q, 4'b1011); else pass_cnt++;
    endtask

    task automatic test_up_wrap();
        load(4'b1101);
        bus.mode = 2'b01;
        step();
        total_cnt++; if (bus.q !== 4'b1110) $display("FAIL up1_q: got %b want %b", bus.q, 4'b1110); else pass_cnt++;
        total_cnt++; if (bus.tc !== 1'b0) $display("FAIL up1_tc: got %b want 0", bus.tc); else pass_cnt++;
        step();
        total_cnt++; if (bus.q !== 4'b1111) $display("FAIL up2_q: got %b want %b", bus.q, 4'b1111); else pass_cnt++;
        total_cnt++; if (bus.tc !== 1'b1) $display("FAIL up2_tc: got %b want 1", bus.tc); else pass_cnt++;
        total_cnt++; if (bus.wrap !== 1'b0) $display("FAIL up2_wrap: got %b want 0", bus.wrap); else pass_cnt++;
        step();
        total_cnt++; if (bus.q !== 4'b0000) $display("FAIL up3_q: got %b want %b", bus.q, 4'b0000); else pass_cnt++;
        total_cnt++; if (bus.wrap !== 1'b1) $display("FAIL up3_wrap: got %b want 1", bus.wrap); else pass_cnt++;
        step();
        total_cnt++; if (bus.q !== 4'b0001) $display("FAIL up4_q: got %b want %b", bus.q, 4'b0001); else pass_cnt++;
        total_cnt++; if (bus.wrap !== 1'b0) $display("FAIL up4_wrap: got %b want 0", bus.wrap); else pass_cnt++;
    endtask

    task automatic test_down_wrap_enable();
        load(4'b0001);
        bus.mode = 2'b10;
        step();
        total_cnt++; if (bus.q !== 4'b0000) $display("FAIL dn1_q: got %b want %b", bus.q, 4'b0000); else pass_cnt++;
        total_cnt++; if (bus.tc !== 1'b1) $display("FAIL dn1_tc: got %b want 1", bus.tc); else pass_cnt++;
        bus.en = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            total_cnt++; if (bus.q !== 4'b0000) $display("FAIL dn_hold_q[%0d]: got %b want %b", n, bus.q, 4'b0000); else pass_cnt++;
            total_cnt++; if (bus.wrap !== 1'b0) $display("FAIL dn_hold_wrap[%0d]: got %b want 0", n, bus.wrap); else pass_cnt++;
        end
        // tc is combinational on mode: drops immediately in JK mode
        bus.mode = 2'b00;
        #1;
        total_cnt++; if (bus.tc !== 1'b0) $display("FAIL tc_mode_follow: got %b want 0", bus.tc); else pass_cnt++;
        bus.mode = 2'b10;
        #1;
        total_cnt++; if (bus.tc !== 1'b1) $display("FAIL tc_mode_back: got %b want 1", bus.tc); else pass_cnt++;
        bus.en = 1'b1;
        step();
        total_cnt++; if (bus.q !== 4'b1111) $display("FAIL dn_wrap_q: got %b want %b", bus.q, 4'b1111); else pass_cnt++;
        total_cnt++; if (bus.wrap !== 1'b1) $display("FAIL dn_wrap_pulse: got %b want 1", bus.wrap); else pass_cnt++;
        total_cnt++; if (bus.qb !== 4'b0000) $display("FAIL dn_wrap_qb: got %b want %b", bus.qb, 4'b0000); else pass_cnt++;
    endtask

    task automatic test_shift();
        logic [3:0] sins;
        logic [3:0] exp_q [4];
        sins = 4'b1101; // applied LSB first: 1,0,1,1
        exp_q[0] = 4'b0001; exp_q[1] = 4'b0010; exp_q[2] = 4'b0101; exp_q[3] = 4'b1011;
        load(4'b0000);
        bus.mode = 2'b11;
        for (int n = 0; n < 4; n++) begin
            bus.sin = sins[n];
            bus.j   = 4'($urandom);
            bus.k   = 4'($urandom);
            step();
            total_cnt++; if (bus.q !== exp_q[n]) $display("FAIL shift%0d_q: got %b want %b", n, bus.q, exp_q[n]); else pass_cnt++;
        end
        total_cnt++; if (bus.tc !== 1'b0) $display("FAIL shift_tc: got %b want 0", bus.tc); else pass_cnt++;
    endtask

    task automatic test_reset_mid_count();
        load(4'b0101);
        bus.mode = 2'b01;
        step();
        total_cnt++; if (bus.q !== 4'b0110) $display("FAIL mid_pre_q: got %b want %b", bus.q, 4'b0110); else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++; if (bus.q !== RV) $display("FAIL mid_rst_q: got %b want %b", bus.q, RV); else pass_cnt++;
        bus.mode = 2'b10;
        step();
        total_cnt++; if (bus.q !== 4'b1001) $display("FAIL mid_down_q: got %b want %b", bus.q, 4'b1001); else pass_cnt++;
        // Reset on a would-be wrap edge: reset wins, no wrap pulse
        load(4'b1111);
        bus.mode = 2'b01;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++; if (bus.q !== RV) $display("FAIL rst_prio_q: got %b want %b", bus.q, RV); else pass_cnt++;
        total_cnt++; if (bus.wrap !== 1'b0) $display("FAIL rst_prio_wrap: got %b want 0", bus.wrap); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.mode  = 2'b00;
        bus.j     = '0;
        bus.k     = '0;
        bus.sin   = 1'b0;
        test_reset();
        test_jk();
        test_up_wrap();
        test_down_wrap_enable();
        test_shift();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
